// File: rtl/serial_test_top.sv
// rtl/serial_test_top.sv - serial register-access test block: 8N1 UART plus byte command FSM over four 32-bit registers
// Host writes/reads REG[0..3]; every response byte is paced by one received byte.

module serial_uart_rx #(
  parameter int BIT_CLKS = 868
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rxd_i,
  output logic       strobe_o,
  output logic [7:0] byte_o
);
  localparam int CW   = $clog2(BIT_CLKS + 1);
  localparam int HALF = BIT_CLKS / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          strobe_q;
  logic [7:0]    byte_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= RX_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      byte_q   <= '0;
    end else begin
      sync1_q  <= rxd_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      strobe_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          // Re-check the start bit half a bit in; a high line means a glitch.
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CW'(BIT_CLKS - 1)) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CW'(BIT_CLKS - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              strobe_q <= 1'b1;
              byte_q   <= shift_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign strobe_o = strobe_q;
  assign byte_o   = byte_q;
endmodule

module serial_uart_tx #(
  parameter int BIT_CLKS = 868
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       txd_o
);
  localparam int CW = $clog2(BIT_CLKS + 1);

  logic          busy_q;
  logic          txd_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else if (!busy_q) begin
      txd_q <= 1'b1;
      if (start_i) begin
        busy_q  <= 1'b1;
        txd_q   <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= '0;
        shift_q <= {1'b1, data_i};
      end
    end else if (cnt_q == CW'(BIT_CLKS - 1)) begin
      cnt_q <= '0;
      // bit_q counts start(0), data(1..8), stop(9); idle after the stop bit ends.
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        txd_q  <= 1'b1;
      end else begin
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bit_q   <= bit_q + 1'b1;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign txd_o  = txd_q;
endmodule

module serial_test_top #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic txd
);
  localparam int BIT_CLKS = CLK_FREQUENCY / BAUD;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WACK, S_RRESP} state_e;

  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       tx_start;

  state_e      state_q;
  logic [7:0]  cmd_q, addr_q;
  logic [2:0]  cnt_q;
  logic [31:0] wbuf_q, rbuf_q;
  logic [31:0] regs_q [4];
  logic        pend_valid_q;
  logic [7:0]  pend_byte_q;

  serial_uart_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
    .clk_i   (clk),
    .reset_i (reset),
    .rxd_i   (rxd),
    .strobe_o(rx_strobe),
    .byte_o  (rx_byte)
  );

  serial_uart_tx #(.BIT_CLKS(BIT_CLKS)) u_tx (
    .clk_i  (clk),
    .reset_i(reset),
    .start_i(tx_start),
    .data_i (pend_byte_q),
    .busy_o (tx_busy),
    .txd_o  (txd)
  );

  assign tx_start = pend_valid_q && !tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (tx_start) pend_valid_q <= 1'b0;
      // A new trigger lands after the clear above, so it overwrites a held byte.
      if (rx_strobe) begin
        case (state_q)
          S_IDLE: begin
            cmd_q   <= rx_byte;
            state_q <= S_ADDR;
          end
          S_ADDR: begin
            addr_q <= rx_byte;
            cnt_q  <= '0;
            if (cmd_q[7]) begin
              rbuf_q  <= regs_q[rx_byte[1:0]];
              state_q <= S_RRESP;
            end else begin
              state_q <= S_WDATA;
            end
          end
          S_WDATA: begin
            wbuf_q[8*cnt_q[1:0] +: 8] <= rx_byte;
            if (cnt_q == 3'd3) begin
              regs_q[addr_q[1:0]] <= {rx_byte, wbuf_q[23:0]};
              cnt_q               <= '0;
              state_q             <= S_WACK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WACK: begin
            pend_valid_q <= 1'b1;
            pend_byte_q  <= 8'h01;
            state_q      <= S_IDLE;
          end
          S_RRESP: begin
            pend_valid_q <= 1'b1;
            case (cnt_q)
              3'd0:    pend_byte_q <= cmd_q;
              3'd1:    pend_byte_q <= addr_q;
              default: begin
                pend_byte_q <= rbuf_q[7:0];
                rbuf_q      <= {8'h00, rbuf_q[31:8]};
              end
            endcase
            if (cnt_q == 3'd5) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_test_top.sv
// tb/tb_serial_test_top.sv - directed bench for serial_test_top with a UART host model
// Runs at BIT_CLKS=16 (1 MHz clock, 62500 baud) so 2000 clocks equal 2 ms.

module tb_serial_test_top;
  localparam int CLK_FREQUENCY = 1_000_000;
  localparam int BAUD          = 62_500;
  localparam int BIT           = CLK_FREQUENCY / BAUD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q [$];
  int tx_frame_err = 0;

  serial_test_top #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD(BAUD)) dut (
    .clk  (clk),
    .reset(reset),
    .rxd  (rxd),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Host-side UART receiver: decodes txd at mid-bit into rx_q.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        if (txd !== 1'b1) tx_frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] exp);
    int t = 0;
    while (rx_q.size() == 0 && t < 700) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rcv"}, rx_q.size() > 0, 1);
    if (rx_q.size() > 0) check(tag, rx_q.pop_front(), exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("txd_in_reset", txd, 1);
    end
    reset = 1'b0;
    rx_q.delete();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] val, input string tag);
    send_byte(8'h00, 1'b1);
    send_byte(addr, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(val[8*i +: 8], 1'b1);
    repeat (300) @(negedge clk);
    check({tag, "_silent"}, rx_q.size(), 0);
    send_byte(8'h5A, 1'b1);
    wait_byte({tag, "_ack"}, 8'h01);
    repeat (300) @(negedge clk);
    check({tag, "_one_ack"}, rx_q.size(), 0);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] val, input bit fast,
                         input string tag);
    logic [7:0] exp [6];
    exp[0] = 8'h80;
    exp[1] = addr;
    for (int i = 0; i < 4; i++) exp[i + 2] = val[8*i +: 8];
    send_byte(8'h80, 1'b1);
    send_byte(addr, 1'b1);
    repeat (300) @(negedge clk);
    check({tag, "_silent"}, rx_q.size(), 0);
    if (fast) begin
      // Back-to-back triggers overlap TX frames, exercising the pending slot.
      for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b1);
      for (int i = 0; i < 6; i++) wait_byte($sformatf("%s_b%0d", tag, i), exp[i]);
    end else begin
      for (int i = 0; i < 6; i++) begin
        send_byte(8'h00, 1'b1);
        wait_byte($sformatf("%s_b%0d", tag, i), exp[i]);
      end
    end
    repeat (300) @(negedge clk);
    check({tag, "_no_extra"}, rx_q.size(), 0);
  endtask

  initial begin
    apply_reset();
    repeat (2000) @(negedge clk);
    check("reset_idle_txd", txd, 1);
    check("reset_no_tx", rx_q.size(), 0);

    do_write(8'h01, 32'h44332211, "wr1");
    do_read(8'h01, 32'h44332211, 1'b0, "rd1");
    do_read(8'h06, 32'h00000000, 1'b0, "rd2");

    do_write(8'hFF, 32'hDEADBEEF, "wr3");
    do_read(8'h03, 32'hDEADBEEF, 1'b1, "rd3");

    send_byte(8'h55, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("ferr_silent", rx_q.size(), 0);
    do_read(8'h01, 32'h44332211, 1'b0, "ferr_rd");

    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    apply_reset();
    repeat (100) @(negedge clk);
    do_read(8'h01, 32'h00000000, 1'b0, "rst_rd1");
    do_read(8'h03, 32'h00000000, 1'b1, "rst_rd3");

    check("tx_stop_bits", tx_frame_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_test_top.md
# serial_test_top

Serial register-access test block. It contains an internal 8N1 UART and a byte-level command FSM that lets a host read and write four 32-bit registers over a two-wire serial link. It sits at the top of a serial bring-up design, with `rxd`/`txd` wired to the host UART. All traffic is host-paced: every response byte is triggered by one received byte.

## Interface
- `CLK_FREQUENCY`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s. Bit period `BIT_CLKS = CLK_FREQUENCY/BAUD`, integer-truncated; 868 at the defaults.
- `clk` input 1: single clock. All logic is rising-edge.
- `reset` input 1: synchronous and active-high.
- `rxd` input 1: serial input, asynchronous to `clk`, idle high.
- `txd` output 1: serial output, idle high.

## Operation
- **UART RX**
  - `rxd` passes through a 2-flop synchronizer before use.
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at `BIT_CLKS/2`; if it reads high, the frame is abandoned.
  - Data bits are sampled every `BIT_CLKS` after that, LSB first.
  - The stop bit is sampled the same way. If it is 0, the byte is discarded (framing error).
  - A valid byte produces a one-cycle `rx_strobe` with `rx_byte`.
- **UART TX**
  - Frame: start 0, 8 data bits LSB first, stop 1. Each bit lasts `BIT_CLKS`.
  - `tx_busy` covers the whole frame.
  - TX and RX run independently (full duplex).
- **Register file**: `REG[0..3]`, 32 bits each, reset to 0. The register is selected by `addr[1:0]`; `addr[7:2]` is ignored.
- **FSM states**: `IDLE`, `ADDR`, `WDATA`, `WACK`, `RRESP`.
  - `IDLE`: on a byte, latch `cmd` and go to `ADDR`.
  - `ADDR`: on a byte, latch `addr`. If `cmd[7]=0` (write), go to `WDATA` with `cnt=0`. If `cmd[7]=1` (read), go to `RRESP` with `cnt=0`.
  - `WDATA`: each byte fills `wbuf[8*cnt +: 8]`, so the first byte is bits [7:0]. On the 4th byte, write `REG[addr[1:0]] <= wbuf` and go to `WACK`.
  - `WACK`: the next byte, of any value, triggers transmission of ACK = 0x01, then return to `IDLE`.
  - `RRESP`: each received byte, of any value, triggers transmission of one response byte in this order:
    - `cmd`
    - `addr`
    - `REG[addr][7:0]`, `[15:8]`, `[23:16]`, `[31:24]`
    - After the 6th trigger, return to `IDLE`.
  - The read value is snapshotted into the shift buffer on the `ADDR`→`RRESP` transition.
  - `cmd[6:0]` is ignored.
- **Pending response**: if a trigger arrives while TX is busy, the response is held in a one-deep pending slot and sent when TX frees up. A trigger arriving while the slot is already full overwrites it.
- Bytes that arrive while no response is due produce no TX output.

## Timing
- Reset values:
  - `txd=1`.
  - FSM in `IDLE`; `cnt=0`.
  - All registers 0.
  - RX/TX idle; pending slot empty.
- Reset mid-frame or mid-transaction aborts immediately. A partial frame is dropped and `txd` returns to 1 on the next edge.
- RX latency: `rx_strobe` fires within 2 clocks of the mid-stop-bit sample, i.e. about 9.5 `BIT_CLKS` after the start edge plus synchronizer delay.
- Response latency: the TX start bit begins at most 3 clocks after the triggering `rx_strobe` when TX is idle.
- Register write takes effect on the clock edge that consumes the 4th data byte. A read issued right after a write returns the new value.
- Back-to-back host bytes with a 1-stop-bit gap must be received without loss.
- There is no inter-byte timeout: the FSM waits indefinitely in any state.

## Test plan
1. **Reset**: assert `reset` for 2 cycles. Required: `txd=1` throughout and after; no TX activity for 2 ms.
2. **Write then ACK**: send 0x00, 0x01, 0x11, 0x22, 0x33, 0x44, then dummy 0x00. Required: no bytes received before the dummy; after the dummy, exactly one byte 0x01; `REG[1]=0x44332211`.
3. **Read back**: after scenario 2, send 0x80, 0x01, then six dummies of 0x00, each sent after the previous response. Required responses in order: 0x80, 0x01, 0x11, 0x22, 0x33, 0x44. The FSM then returns to `IDLE`.
4. **Read of unwritten register**: send 0x80, 0x06, then 6 dummies. Required: 0x80, 0x06, 0x00, 0x00, 0x00, 0x00, since 0x06 maps to `REG[2]`.
5. **Framing error**: send a byte with stop bit 0, then a valid read of `REG[1]`. Required: the bad byte is ignored and the read returns the correct 6-byte sequence.
6. **Reset mid-write**: send 0x00, 0x01, 0xAA, assert `reset`, then perform a read of `REG[1]`. Required: `REG[1]` reads 0x00000000 and the FSM restarts cleanly at `IDLE`.
